// File: rtl/mdio_pkg.sv
// Shared types and field positions for the Clause-22 MDIO master.
package mdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_FRAME,
    ST_DONE
  } state_t;

  localparam int FRAME_LEN = 32;

  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: one bit cell is P_CLK_DIV low clocks then P_CLK_DIV high clocks.
// drive_stb marks the cell-start edge, sample_stb the edge on which mdc rises.
module mdio_clk_gen #(
  parameter int P_CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic drive_stb,
  output logic sample_stb
);

  localparam int CW = $clog2(2 * P_CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(P_CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * P_CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;

  always_comb begin
    cnt_d = '0;
    mdc_d = 1'b0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      mdc_d = (cnt_q >= HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc        = mdc_q;
  assign drive_stb  = en && (cnt_q == '0);
  assign sample_stb = en && (cnt_q == HALF);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: preamble plus 32-bit frame on MDC/MDIO, read data captured
// from the TA bit onward; result returned with a one-cycle done pulse.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_CLK_DIV      = 25,
  parameter int P_PREAMBLE_LEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_DATA_WIDTH-1:0] mdio_wr_data,
  input  logic                    mdio_en,
  output logic [P_DATA_WIDTH-1:0] mdio_rd_data,
  output logic                    mdio_done,
  output logic                    mdio_busy,
  output logic                    mdc,
  output logic                    mdio_o,
  output logic                    mdio_t,
  input  logic                    mdio_i
);

  localparam logic [5:0] PRE_LAST = (P_PREAMBLE_LEN == 0) ? 6'd0 : 6'(P_PREAMBLE_LEN - 1);
  localparam logic [5:0] FRM_LEN  = 6'(FRAME_LEN);
  localparam logic [5:0] TA_HI    = 6'(TA_MSB);

  state_t                  state_q, state_d;
  logic [P_DATA_WIDTH-1:0] cmd_q, cmd_d;
  logic [P_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic                    o_q, o_d, t_q, t_d, done_q, done_d, busy_q, busy_d;

  logic       active, drive_stb, sample_stb, is_read;
  logic [5:0] frame_idx, samp_idx;

  assign active  = (state_q == ST_PREAMBLE) || (state_q == ST_FRAME);
  assign is_read = (cmd_q[OP_MSB:OP_LSB] == OP_READ);
  // bit_cnt counts frame cells already started: the next cell to drive is 31-n,
  // the cell currently in progress is 32-n.
  assign frame_idx = 6'd31 - bit_cnt_q;
  assign samp_idx  = 6'd32 - bit_cnt_q;

  mdio_clk_gen #(.P_CLK_DIV(P_CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (active),
    .mdc       (mdc),
    .drive_stb (drive_stb),
    .sample_stb(sample_stb)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rd_data_d = rd_data_q;
    bit_cnt_d = bit_cnt_q;
    o_d       = o_q;
    t_d       = t_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mdio_en) begin
          cmd_d     = mdio_wr_data;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = (P_PREAMBLE_LEN == 0) ? ST_FRAME : ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (drive_stb) begin
          o_d       = 1'b1;
          t_d       = 1'b0;
          bit_cnt_d = bit_cnt_q + 6'd1;
          // Enter FRAME while the last preamble cell is still running.
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = ST_FRAME;
            bit_cnt_d = '0;
          end
        end
      end
      ST_FRAME: begin
        if (sample_stb && (bit_cnt_q != '0) && is_read && (samp_idx <= TA_HI)) begin
          cmd_d[samp_idx[4:0]] = mdio_i;
        end
        if (drive_stb) begin
          if (bit_cnt_q == FRM_LEN) begin
            state_d   = ST_DONE;
            rd_data_d = cmd_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            o_d       = 1'b1;
            t_d       = 1'b1;
          end else begin
            o_d       = cmd_q[frame_idx[4:0]];
            t_d       = is_read && (frame_idx <= TA_HI);
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      rd_data_q <= '0;
      bit_cnt_q <= '0;
      o_q       <= 1'b1;
      t_q       <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rd_data_q <= rd_data_d;
      bit_cnt_q <= bit_cnt_d;
      o_q       <= o_d;
      t_q       <= t_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign mdio_rd_data = rd_data_q;
  assign mdio_done    = done_q;
  assign mdio_busy    = busy_q;
  assign mdio_o       = o_q;
  assign mdio_t       = t_q;

endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management master that consumes the command word and one-cycle start strobe from the register file's MDIO TX register. It serialises a preamble plus a 32-bit management frame on MDC/MDIO, and captures read data from the PHY. It returns the completed frame word plus a done pulse to the register file, which stores it, with turnaround bits masked, in the MDIO RX register. It sits between the AXI-lite register slave and the Ethernet PHY pins/IOBUF.

## Interface
- P_DATA_WIDTH, 32, command/response word width; only 32 is supported.
- P_CLK_DIV, 25, clk cycles per MDC half-period; minimum 2. MDC period = 2*P_CLK_DIV.
- P_PREAMBLE_LEN, 32, number of preamble '1' bits before ST; 0 is legal and disables the preamble.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- mdio_wr_data  in  32  command frame: [31:30] ST (01), [29:28] OP (01 write, 10 read), [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA.
- mdio_en  in  1  single-cycle start strobe.
- mdio_rd_data  out  32  completed frame word, same layout.
- mdio_done  out  1  single-cycle completion pulse.
- mdio_busy  out  1  transaction in progress.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output data.
- mdio_t  out  1  tristate control; 1 = released (high-Z).
- mdio_i  in  1  MDIO pin input, already synchronised externally.

## Operation
- States: IDLE, PREAMBLE, FRAME, DONE.
- IDLE
  - mdc=0, mdio_t=1, mdio_o=1, busy=0.
  - When mdio_en=1, latch mdio_wr_data into cmd, clear the bit counter, set busy.
  - Next state is PREAMBLE, or FRAME if P_PREAMBLE_LEN=0.
- PREAMBLE: drive mdio_o=1, mdio_t=0 for P_PREAMBLE_LEN bit cells, then go to FRAME.
- FRAME: 32 bit cells, MSB (bit 31) first.
- Write frame (OP≠10): all 32 bits driven from cmd, mdio_t=0.
- Read frame (OP=10):
  - Bits 31..18 are driven.
  - From bit 17 (first TA bit) to the end, mdio_t=1 and the pin is sampled.
  - Captured bits 17..0 replace cmd[17:0].
- On a write, the sampled bits equal the driven bits; mdio_rd_data = cmd unchanged.
- DONE (one cycle)
  - mdio_rd_data <= cmd, mdio_done=1, busy=0, mdio_t=1.
  - Next state is IDLE.
- mdio_en while busy is ignored; no queueing.
- OP values 00/11 are treated as writes; no error reporting.
- mdio_rd_data holds its value until the next DONE.

## Timing
- Reset values: mdc=0, mdio_o=1, mdio_t=1, mdio_done=0, mdio_busy=0, mdio_rd_data=0, state IDLE.
- Bit cell = 2*P_CLK_DIV clk cycles:
  - Low phase: MDC=0 for P_CLK_DIV cycles.
  - High phase: MDC=1 for P_CLK_DIV cycles.
- mdio_o and mdio_t update on the first clk of the low phase, i.e. at the MDC falling edge (cell start).
- mdio_i is sampled on the last clk of the low phase, registered on the same edge at which mdc goes 1.
- mdio_en is seen at edge 0; the first cell starts at edge 1.
- mdio_done is high for the cycle after the final cell's high phase.
- Latency from mdio_en to mdio_done = 1 + (P_PREAMBLE_LEN+32)*2*P_CLK_DIV cycles.
- MDC is held low whenever the state is not PREAMBLE or FRAME.
- rst mid-transaction:
  - Immediate return to reset values.
  - No mdio_done; mdio_rd_data cleared.
- mdio_en asserted in the DONE cycle is ignored; it is accepted only from IDLE.

## Structure
- Package mdio_pkg:
  - state enum.
  - Field localparams: ST/OP/PHYAD/REGAD/TA/DATA positions.
  - OP_WRITE=2'b01, OP_READ=2'b10, frame length 32.
- Sub-module mdio_clk_gen:
  - Free-running when enabled; restarts at phase 0 on enable.
  - Outputs mdc, drive_stb (cell start) and sample_stb (last low-phase clk).
- Top-level FSM holds cmd, the bit counter (6 bits, covering preamble and frame) and the output registers.

## Test plan
All scenarios use P_CLK_DIV=2 and P_PREAMBLE_LEN=32.
- Reset: hold rst 3 cycles → mdc=0, mdio_t=1, mdio_o=1, done=0, busy=0, rd_data=0.
- Write 0x5082_1234 (PHY 1, reg 0, data 0x1234):
  - 32 ones, then pin sequence equal to the word MSB first, mdio_t=0 throughout.
  - done exactly at cycle 257 after mdio_en.
  - rd_data=0x5082_1234.
- Read 0x6086_0000 (PHY 1, reg 1), PHY model drives TA=Z0 and data 0x796D:
  - mdio_t=1 from bit 17 on.
  - rd_data=0x6086_796D at done, given the PHY model drives TA as Z then 0.
- mdio_en re-pulsed at cycle 100 of a transaction:
  - Ignored; exactly one done.
  - rd_data reflects the first command only.
- rst asserted at cycle 150 of a read:
  - Outputs return to reset values next cycle; no done pulse.
  - A new write afterwards completes normally with correct latency.
- Back-to-back: mdio_en the cycle after done → accepted; second done at exactly +257 cycles.
